// File: rtl/can_rx_pkg.sv
// Shared constants for the CAN receive path: message width, field slices, pointer sizing.
package can_rx_pkg;
  localparam int CAN_MSG_W = 128;

  localparam int ID_HI  = 127;
  localparam int ID_LO  = 96;
  localparam int DLC_HI = 95;
  localparam int DLC_LO = 64;
  localparam int DW1_HI = 63;
  localparam int DW1_LO = 32;
  localparam int DW2_HI = 31;
  localparam int DW2_LO = 0;

  // Index bits plus one wrap bit, so full and empty stay distinguishable.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/can_rx_fifo_mem.sv
// Message store: one synchronous write port, one asynchronous read port.
// Write takes effect at the clock edge; the array has no reset.
module can_rx_fifo_mem #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int WIDTH  = 128
) (
  input  logic              sys_clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_idx,
  input  logic [WIDTH-1:0]  wr_dat,
  input  logic [ADDR_W-1:0] rd_idx,
  output logic [WIDTH-1:0]  rd_dat
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge sys_clk) begin
    if (wr_en) mem[wr_idx] <= wr_dat;
  end

  assign rd_dat = mem[rd_idx];
endmodule

// File: rtl/can_rx_fifo.sv
// Receive message FIFO, first-word-fall-through head on rxfifo_op (0 when empty).
// Writes into a full FIFO are dropped and flagged; reads of an empty FIFO are ignored and flagged.
module can_rx_fifo
  import can_rx_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int ADDR_W    = 4,
  parameter int WIDTH     = CAN_MSG_W,
  parameter int AFULL_LVL = 12
) (
  input  logic              sys_clk,
  input  logic              IP2Can_reset,
  input  logic [WIDTH-1:0]  rx_msg_in,
  input  logic              rx_msg_wr,
  input  logic              rxfifo_rd,
  input  logic              rxfifo_flush,
  input  logic              ovf_clr,
  output logic [WIDTH-1:0]  rxfifo_op,
  output logic              rxfifo_empty,
  output logic              rxfifo_full,
  output logic              rxfifo_afull,
  output logic [ADDR_W:0]   rxfifo_count,
  output logic              rx_ovf,
  output logic              rx_ovf_pulse,
  output logic              rx_unf_pulse
);
  localparam int PTR_W = ptr_w(DEPTH);
  localparam logic [PTR_W-1:0] AFULL_CNT = PTR_W'(AFULL_LVL);

  logic [PTR_W-1:0]  wr_ptr, rd_ptr, occ;
  logic [ADDR_W-1:0] wr_idx, rd_idx;
  logic [WIDTH-1:0]  head_dat;
  logic              wr_acc, rd_acc, wr_drop, rd_unf;

  assign wr_idx = wr_ptr[ADDR_W-1:0];
  assign rd_idx = rd_ptr[ADDR_W-1:0];
  assign occ    = wr_ptr - rd_ptr;

  assign rxfifo_empty = (wr_ptr == rd_ptr);
  assign rxfifo_full  = (wr_idx == rd_idx) && (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]);
  assign rxfifo_afull = (occ >= AFULL_CNT);
  assign rxfifo_count = occ;
  assign rxfifo_op    = rxfifo_empty ? '0 : head_dat;

  // A pop in the same cycle frees the slot, so a write at full still lands.
  assign rd_acc  = rxfifo_rd && !rxfifo_empty && !rxfifo_flush;
  assign wr_acc  = rx_msg_wr && (!rxfifo_full || rd_acc) && !rxfifo_flush;
  assign wr_drop = rx_msg_wr && rxfifo_full && !rxfifo_rd && !rxfifo_flush;
  assign rd_unf  = rxfifo_rd && rxfifo_empty && !rxfifo_flush;

  always_ff @(posedge sys_clk or negedge IP2Can_reset) begin
    if (!IP2Can_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rxfifo_flush)  rd_ptr <= wr_ptr;
      else if (rd_acc)   rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge IP2Can_reset) begin
    if (!IP2Can_reset) begin
      rx_ovf       <= 1'b0;
      rx_ovf_pulse <= 1'b0;
      rx_unf_pulse <= 1'b0;
    end else begin
      rx_ovf_pulse <= wr_drop;
      rx_unf_pulse <= rd_unf;
      if (wr_drop)      rx_ovf <= 1'b1;
      else if (ovf_clr) rx_ovf <= 1'b0;
    end
  end

  can_rx_fifo_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .WIDTH  (WIDTH)
  ) u_mem (
    .sys_clk (sys_clk),
    .wr_en   (wr_acc),
    .wr_idx  (wr_idx),
    .wr_dat  (rx_msg_in),
    .rd_idx  (rd_idx),
    .rd_dat  (head_dat)
  );
endmodule

// File: tb/tb_can_rx_fifo.sv
// Bench for can_rx_fifo: vector table, directed corner sequences, random traffic vs a queue model.
module tb_can_rx_fifo;
  localparam int DEPTH = 16;
  localparam int AFULL_LVL = 12;

  logic         sys_clk = 1'b0;
  logic         IP2Can_reset;
  logic [127:0] rx_msg_in;
  logic         rx_msg_wr, rxfifo_rd, rxfifo_flush, ovf_clr;
  logic [127:0] rxfifo_op;
  logic         rxfifo_empty, rxfifo_full, rxfifo_afull;
  logic [4:0]   rxfifo_count;
  logic         rx_ovf, rx_ovf_pulse, rx_unf_pulse;

  int checks = 0;
  int failures = 0;

  always #5 sys_clk = ~sys_clk;

  can_rx_fifo #(.DEPTH(DEPTH), .ADDR_W(4), .WIDTH(128), .AFULL_LVL(AFULL_LVL)) dut (
    .sys_clk      (sys_clk),
    .IP2Can_reset (IP2Can_reset),
    .rx_msg_in    (rx_msg_in),
    .rx_msg_wr    (rx_msg_wr),
    .rxfifo_rd    (rxfifo_rd),
    .rxfifo_flush (rxfifo_flush),
    .ovf_clr      (ovf_clr),
    .rxfifo_op    (rxfifo_op),
    .rxfifo_empty (rxfifo_empty),
    .rxfifo_full  (rxfifo_full),
    .rxfifo_afull (rxfifo_afull),
    .rxfifo_count (rxfifo_count),
    .rx_ovf       (rx_ovf),
    .rx_ovf_pulse (rx_ovf_pulse),
    .rx_unf_pulse (rx_unf_pulse)
  );

  // Reference model: a queue of messages plus the flags the rules define.
  logic [127:0] mq[$];
  logic         m_ovf, m_ovfp, m_unfp;

  function automatic logic [127:0] m_head();
    return (mq.size() > 0) ? mq[0] : 128'd0;
  endfunction

  task automatic model_step(input logic wr, input logic rd, input logic fl,
                            input logic clr, input logic [127:0] din);
    bit was_full, was_empty, popped;
    was_full  = (mq.size() == DEPTH);
    was_empty = (mq.size() == 0);
    m_ovfp = 1'b0;
    m_unfp = 1'b0;
    if (fl) begin
      mq.delete();
    end else begin
      popped = rd && !was_empty;
      if (rd && was_empty) m_unfp = 1'b1;
      if (wr && was_full && !rd) m_ovfp = 1'b1;
      if (popped) void'(mq.pop_front());
      if (wr && (!was_full || popped)) mq.push_back(din);
    end
    if (m_ovfp) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".count"}, 128'(rxfifo_count), 128'(mq.size()));
    chk({tag, ".op"}, rxfifo_op, m_head());
    chk({tag, ".empty"}, 128'(rxfifo_empty), 128'(mq.size() == 0));
    chk({tag, ".full"}, 128'(rxfifo_full), 128'(mq.size() == DEPTH));
    chk({tag, ".afull"}, 128'(rxfifo_afull), 128'(mq.size() >= AFULL_LVL));
    chk({tag, ".ovf"}, 128'(rx_ovf), 128'(m_ovf));
    chk({tag, ".ovfp"}, 128'(rx_ovf_pulse), 128'(m_ovfp));
    chk({tag, ".unfp"}, 128'(rx_unf_pulse), 128'(m_unfp));
  endtask

  // Called #1 after an edge: drive, take one edge, sample #1 after it.
  task automatic apply(input logic wr, input logic rd, input logic fl,
                       input logic clr, input logic [127:0] din);
    rx_msg_wr = wr; rxfifo_rd = rd; rxfifo_flush = fl; ovf_clr = clr; rx_msg_in = din;
    @(posedge sys_clk);
    model_step(wr, rd, fl, clr, din);
    #1;
    rx_msg_wr = 0; rxfifo_rd = 0; rxfifo_flush = 0; ovf_clr = 0;
  endtask

  typedef struct {
    logic         wr, rd, fl, clr;
    logic [127:0] din;
    int           cnt;
    logic [127:0] op;
    logic         ovfp, unfp;
  } vec_t;

  vec_t tbl[7];
  localparam logic [127:0] MSG_A = 128'h00000123_00000008_DEADBEEF_CAFEF00D;
  localparam logic [127:0] MSG_B = 128'h00000456_00000004_11112222_00000000;
  localparam logic [127:0] MSG_C = 128'h00000789_00000002_33334444_55556666;
  localparam logic [127:0] MSG_D = 128'h0000000D_00000001_77778888_99990000;
  localparam logic [127:0] MSG_E = 128'h0000000E_00000008_AAAABBBB_CCCCDDDD;

  initial begin
    logic [127:0] w;
    int lim;
    //        wr rd fl clr din    cnt op     ovfp unfp
    tbl[0] = '{0, 1, 0, 0, '0,    0, '0,    0, 1};
    tbl[1] = '{1, 0, 0, 0, MSG_A, 1, MSG_A, 0, 0};
    tbl[2] = '{1, 1, 0, 0, MSG_B, 1, MSG_B, 0, 0};
    tbl[3] = '{1, 0, 0, 0, MSG_C, 2, MSG_B, 0, 0};
    tbl[4] = '{1, 0, 1, 0, MSG_D, 0, '0,    0, 0};
    tbl[5] = '{1, 1, 0, 0, MSG_E, 1, MSG_E, 0, 1};
    tbl[6] = '{0, 0, 0, 1, '0,    1, MSG_E, 0, 0};

    IP2Can_reset = 0;
    rx_msg_wr = 0; rxfifo_rd = 0; rxfifo_flush = 0; ovf_clr = 0; rx_msg_in = '0;
    m_ovf = 0; m_ovfp = 0; m_unfp = 0;
    repeat (2) @(posedge sys_clk);
    #1;
    chk("rst.count", 128'(rxfifo_count), 128'd0);
    chk("rst.empty", 128'(rxfifo_empty), 128'd1);
    chk("rst.full", 128'(rxfifo_full), 128'd0);
    chk("rst.afull", 128'(rxfifo_afull), 128'd0);
    chk("rst.op", rxfifo_op, 128'd0);
    chk("rst.ovf", 128'(rx_ovf), 128'd0);
    chk("rst.pulses", 128'({rx_ovf_pulse, rx_unf_pulse}), 128'd0);
    IP2Can_reset = 1;

    for (int i = 0; i < 7; i++) begin
      apply(tbl[i].wr, tbl[i].rd, tbl[i].fl, tbl[i].clr, tbl[i].din);
      chk($sformatf("vec%0d.count", i), 128'(rxfifo_count), 128'(tbl[i].cnt));
      chk($sformatf("vec%0d.empty", i), 128'(rxfifo_empty), 128'(tbl[i].cnt == 0));
      chk($sformatf("vec%0d.op", i), rxfifo_op, tbl[i].op);
      chk($sformatf("vec%0d.ovfp", i), 128'(rx_ovf_pulse), 128'(tbl[i].ovfp));
      chk($sformatf("vec%0d.unfp", i), 128'(rx_unf_pulse), 128'(tbl[i].unfp));
    end
    apply(0, 0, 1, 0, '0);
    chk_model("preflush");

    // Fill to full with k in the low word; afull must track count >= 12.
    for (int k = 0; k < DEPTH; k++) begin
      w = {32'h100 + 32'(k), 32'h8, 32'hA5A5_0000 + 32'(k), 32'(k)};
      apply(1, 0, 0, 0, w);
      chk_model($sformatf("fill%0d", k));
      chk($sformatf("fill%0d.afull_lvl", k), 128'(rxfifo_afull), 128'(k + 1 >= AFULL_LVL));
    end
    chk("full.flag", 128'(rxfifo_full), 128'd1);

    apply(1, 0, 0, 0, {4{32'hBAD0_0017}});
    chk_model("ovf.drop");
    chk("ovf.pulse", 128'(rx_ovf_pulse), 128'd1);
    chk("ovf.head", rxfifo_op[31:0], 128'd0);
    apply(0, 0, 0, 0, '0);
    chk("ovf.pulse_gone", 128'(rx_ovf_pulse), 128'd0);
    chk("ovf.sticky", 128'(rx_ovf), 128'd1);
    apply(1, 0, 0, 1, {4{32'hBAD0_0018}});
    chk("ovf.clr_lose", 128'(rx_ovf), 128'd1);
    apply(0, 0, 0, 1, '0);
    chk("ovf.clr", 128'(rx_ovf), 128'd0);
    chk_model("ovf.after");

    // Full with simultaneous write and read: count holds, no overflow.
    w = {32'h0, 32'h0, 32'hFEED_FACE, 32'd99};
    apply(1, 1, 0, 0, w);
    chk_model("fullrw");
    chk("fullrw.count", 128'(rxfifo_count), 128'd16);
    chk("fullrw.ovfp", 128'(rx_ovf_pulse), 128'd0);
    for (int k = 1; k < DEPTH; k++) begin
      chk($sformatf("drain%0d.op", k), rxfifo_op[31:0], 128'(k));
      apply(0, 1, 0, 0, '0);
      chk_model($sformatf("drain%0d", k));
    end
    chk("drain.last", rxfifo_op, w);
    apply(0, 1, 0, 0, '0);
    chk("drain.empty", 128'(rxfifo_empty), 128'd1);
    chk("drain.op0", rxfifo_op, 128'd0);
    apply(0, 1, 0, 0, '0);
    chk_model("unf.only");

    // Flush with 5 entries and a concurrent write; sticky flag untouched.
    for (int k = 0; k < 5; k++) apply(1, 0, 0, 0, 128'(k + 500));
    apply(1, 0, 1, 0, 128'd777);
    chk_model("flush5");
    chk("flush5.count", 128'(rxfifo_count), 128'd0);

    // Asynchronous reset between edges.
    for (int k = 0; k < 3; k++) apply(1, 0, 0, 0, 128'(k + 900));
    rx_msg_wr = 1; rx_msg_in = 128'd999;
    #2;
    IP2Can_reset = 0;
    #1;
    chk("arst.count", 128'(rxfifo_count), 128'd0);
    chk("arst.empty", 128'(rxfifo_empty), 128'd1);
    chk("arst.op", rxfifo_op, 128'd0);
    rx_msg_wr = 0;
    mq.delete();
    m_ovf = 0; m_ovfp = 0; m_unfp = 0;
    #1;
    IP2Can_reset = 1;

    // Random traffic, alternating write-heavy and read-heavy phases.
    for (int n = 0; n < 3000; n++) begin
      logic wr, rd, fl, clr;
      lim = ((n / 200) % 2 == 0) ? 75 : 30;
      wr  = ($urandom_range(99) < lim);
      rd  = ($urandom_range(99) < 100 - lim);
      fl  = ($urandom_range(99) < 2);
      clr = ($urandom_range(99) < 5);
      w   = {$urandom, $urandom, $urandom, $urandom};
      apply(wr, rd, fl, clr, w);
      chk_model($sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
